// File: rtl/multi_pulse_hs_pkg.sv
// Shared types and helpers for the multi-channel pulse handshake transmitter.
package multi_pulse_hs_pkg;

    // Per-channel handshake state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } hs_state_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous level signal.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through STAGES flops; reset clears the chain.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/multi_pulse_handshake_tx.sv
// N-channel pulse transmitter. Each accepted pulse_in becomes one 4-phase
// req/ack handshake; pulses arriving during a handshake are queued per channel.
// Optional watchdog: define MULTI_PULSE_HS_TIMEOUT_EN to add the per-phase
// timeout and the timeout_pulse output.
//
// Handshake: req_out rises to offer an event; the receiver raises ack once it
// has taken it; req_out then falls and the receiver drops ack, which completes
// the transfer. A new req_out is only raised after ack has been seen low.
module multi_pulse_handshake_tx
    import multi_pulse_hs_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEPTH          = 7,
    parameter int SYNC_STAGES    = 2
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [NUM_CH-1:0]                   pulse_in,
    input  logic [NUM_CH-1:0]                   ack_in,
    output logic [NUM_CH-1:0]                   req_out,
    output logic [NUM_CH*cnt_width(DEPTH)-1:0]  pending_cnt,
    output logic [NUM_CH-1:0]                   busy,
    output logic [NUM_CH-1:0]                   done_pulse,
    output logic [NUM_CH-1:0]                   overflow,
    input  logic [NUM_CH-1:0]                   clear_overflow
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]                   timeout_pulse
`endif
);

    localparam int CNT_W = cnt_width(DEPTH);
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        hs_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             req_q, done_q, done_d, ovf_q;
        logic             ack_s, dec, drop;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
        logic [WD_W-1:0]  wd_q, wd_d;
        logic             to_q, to_d, expire;
`endif

        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (ack_in[k]),
            .q       (ack_s)
        );

`ifdef MULTI_PULSE_HS_TIMEOUT_EN
        // Last cycle a channel may spend in REQ or WAIT_LOW.
        assign expire = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

        // Next state, completion/decrement strobes and queue counter update.
        always_comb begin
            state_d = state_q;
            dec     = 1'b0;
            done_d  = 1'b0;
            drop    = 1'b0;
            cnt_d   = cnt_q;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
            to_d    = 1'b0;
            wd_d    = '0;
`endif
            case (state_q)
                IDLE:     if (cnt_q != '0) state_d = REQ;
                REQ:      if (ack_s) begin
                              state_d = WAIT_LOW;
                              dec     = 1'b1;
                          end
                WAIT_LOW: if (!ack_s) begin
                              state_d = IDLE;
                              done_d  = 1'b1;
                          end
                default:  state_d = IDLE;
            endcase
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
            // A phase that has not progressed in time is abandoned.
            if (expire && (state_d == state_q)) begin
                state_d = IDLE;
                dec     = (state_q == REQ);
                to_d    = 1'b1;
            end
            if ((state_d == state_q) && (state_q != IDLE)) wd_d = wd_q + 1'b1;
`endif
            // A full queue only drops the pulse when nothing leaves it this cycle.
            drop = pulse_in[k] && !dec && (cnt_q == CNT_W'(DEPTH));
            if (pulse_in[k] && !dec && !drop) cnt_d = cnt_q + 1'b1;
            else if (!pulse_in[k] && dec)     cnt_d = cnt_q - 1'b1;
        end

        // State, counter and registered outputs; set of overflow beats clear.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
                wd_q    <= '0;
                to_q    <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= (state_d == REQ);
                done_q  <= done_d;
                if (drop)                   ovf_q <= 1'b1;
                else if (clear_overflow[k]) ovf_q <= 1'b0;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
                wd_q    <= wd_d;
                to_q    <= to_d;
`endif
            end
        end

        assign req_out[k]                     = req_q;
        assign pending_cnt[k*CNT_W +: CNT_W]  = cnt_q;
        assign busy[k]                        = (state_q != IDLE) || (cnt_q != '0);
        assign done_pulse[k]                  = done_q;
        assign overflow[k]                    = ovf_q;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
        assign timeout_pulse[k]               = to_q;
`endif
    end

endmodule

// File: tb/tb_multi_pulse_handshake_tx.sv
// Bench for multi_pulse_handshake_tx: directed scenarios plus a randomized
// run against a transaction-level scoreboard. Define MULTI_PULSE_HS_TIMEOUT_EN
// to also exercise the watchdog.
`timescale 1ns/1ps
module tb_multi_pulse_handshake_tx;

    localparam int NUM_CH      = 4;
    localparam int DEPTH       = 7;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 3;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`endif

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       pulse_in;
    logic [NUM_CH-1:0]       ack_in;
    logic [NUM_CH-1:0]       req_out;
    logic [NUM_CH*CNT_W-1:0] pending_cnt;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done_pulse;
    logic [NUM_CH-1:0]       overflow;
    logic [NUM_CH-1:0]       clear_overflow;
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
    logic [NUM_CH-1:0]       timeout_pulse;
`endif

    logic [NUM_CH-1:0]       ack_man;
    logic [NUM_CH-1:0]       rx_en;
    int                      rx_dly [NUM_CH];

    int tests_run    = 0;
    int tests_failed = 0;
    logic [1:0] exp_q[$];

    int done_cnt [NUM_CH];
    int rise_cnt [NUM_CH];
    logic [NUM_CH-1:0] req_prev = '0;

    multi_pulse_handshake_tx #(
        .NUM_CH         (NUM_CH),
        .DEPTH          (DEPTH),
        .SYNC_STAGES    (SYNC_STAGES)
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pulse_in       (pulse_in),
        .ack_in         (ack_in),
        .req_out        (req_out),
        .pending_cnt    (pending_cnt),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef MULTI_PULSE_HS_TIMEOUT_EN
        ,
        .timeout_pulse  (timeout_pulse)
`endif
    );

    // Clock.
    always #5 clock = ~clock;

    // Global time bound.
    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    // Receiver model per channel: follows req_out with a programmable delay.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
        logic ack_r  = 1'b0;
        int   wait_n = 0;
        always @(posedge clock) begin
            if (!rx_en[g]) begin
                ack_r  <= 1'b0;
                wait_n <= 0;
            end else if (req_out[g] != ack_r) begin
                if (wait_n >= rx_dly[g]) begin
                    ack_r  <= req_out[g];
                    wait_n <= 0;
                end else begin
                    wait_n <= wait_n + 1;
                end
            end else begin
                wait_n <= 0;
            end
        end
        assign ack_in[g] = ack_r | ack_man[g];
    end

    // Event monitor: completed handshakes and req_out rising edges.
    always @(negedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (done_pulse[i] === 1'b1) done_cnt[i]++;
            if (req_out[i] === 1'b1 && req_prev[i] === 1'b0) rise_cnt[i]++;
        end
        req_prev = req_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [CNT_W-1:0] pend(input int k);
        return pending_cnt[k*CNT_W +: CNT_W];
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] m);
        pulse_in = m;
        tick();
        pulse_in = '0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((busy != '0 || ack_in != '0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_settle"}, 32'(n < budget), 32'd1);
    endtask

    int base_done [NUM_CH];
    int base_rise [NUM_CH];
    int peak;
    int n;
    int accepted [NUM_CH];
    int exp_done [NUM_CH];
    logic [NUM_CH-1:0] m;

    task automatic snap();
        for (int i = 0; i < NUM_CH; i++) begin
            base_done[i] = done_cnt[i];
            base_rise[i] = rise_cnt[i];
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        pulse_in       = '0;
        clear_overflow = '0;
        ack_man        = '0;
        rx_en          = '0;
        for (int i = 0; i < NUM_CH; i++) rx_dly[i] = 2;
        repeat (3) tick();

        // Reset state.
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        rx_en   = '1;
        tick();

        // Single pulse on ch0 with latency checks.
        snap();
        pulse(4'b0001);
        check("t1_pend_after_pulse", 32'(pend(0)), 32'd1);
        check("t1_req_not_yet", 32'(req_out), 32'd0);
        tick();
        check("t1_req_rise", 32'(req_out), 32'b0001);
        wait_quiet("t1", 300);
        check("t1_done_cnt", 32'(done_cnt[0] - base_done[0]), 32'd1);
        check("t1_pending_end", 32'(pending_cnt), 32'd0);
        for (int i = 1; i < NUM_CH; i++)
            check("t1_other_idle", 32'(rise_cnt[i] - base_rise[i]), 32'd0);

        // Five pulses on ch1, slow receiver.
        rx_dly[1] = 9;
        snap();
        peak = 0;
        for (int p = 0; p < 5; p++) begin
            pulse(4'b0010);
            if (int'(pend(1)) > peak) peak = int'(pend(1));
            tick();
            if (int'(pend(1)) > peak) peak = int'(pend(1));
        end
        check("t2_peak", 32'(peak >= 4 && peak <= 5), 32'd1);
        n = 0;
        while (done_pulse[1] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t2_first_done_seen", 32'(n < 200), 32'd1);
        check("t2_idle_gap_req_low", 32'(req_out[1]), 32'd0);
        tick();
        check("t2_next_req_high", 32'(req_out[1]), 32'd1);
        wait_quiet("t2", 1500);
        check("t2_done_cnt", 32'(done_cnt[1] - base_done[1]), 32'd5);
        check("t2_req_rises", 32'(rise_cnt[1] - base_rise[1]), 32'd5);
        check("t2_no_ovf", 32'(overflow), 32'd0);
        rx_dly[1] = 2;

        // Saturation and overflow on ch2.
        rx_en[2] = 1'b0;
        snap();
        for (int p = 0; p < 9; p++) pulse(4'b0100);
        check("t3_pend_sat", 32'(pend(2)), 32'd7);
        check("t3_ovf_set", 32'(overflow), 32'b0100);
        check("t3_req_held", 32'(req_out[2]), 32'd1);
        clear_overflow = 4'b0100;
        tick();
        clear_overflow = '0;
        check("t3_ovf_clear", 32'(overflow), 32'd0);
        check("t3_pend_kept", 32'(pend(2)), 32'd7);
        rx_en[2] = 1'b1;
        wait_quiet("t3", 2000);
        check("t3_done_cnt", 32'(done_cnt[2] - base_done[2]), 32'd7);

        // Full ch3 queue: pulse on the decrement cycle is accepted.
        rx_en[3] = 1'b0;
        snap();
        for (int p = 0; p < 7; p++) pulse(4'b1000);
        check("t4_pend_full", 32'(pend(3)), 32'd7);
        ack_man[3] = 1'b1;
        tick();
        tick();
        pulse(4'b1000);
        check("t4_pend_stays", 32'(pend(3)), 32'd7);
        check("t4_no_ovf", 32'(overflow[3]), 32'd0);
        check("t4_req_dropped", 32'(req_out[3]), 32'd0);
        ack_man[3] = 1'b0;
        rx_en[3]   = 1'b1;
        wait_quiet("t4", 2000);
        check("t4_done_cnt", 32'(done_cnt[3] - base_done[3]), 32'd8);

        // All channels at once with skewed receivers.
        rx_dly[0] = 1; rx_dly[1] = 3; rx_dly[2] = 5; rx_dly[3] = 7;
        snap();
        pulse(4'b1111);
        wait_quiet("t5", 500);
        for (int i = 0; i < NUM_CH; i++)
            check("t5_done_each", 32'(done_cnt[i] - base_done[i]), 32'd1);

        // Reset in the middle of stalled handshakes with overflow pending.
        rx_en = '0;
        for (int p = 0; p < 8; p++) pulse(4'b1111);
        check("t5_ovf_all", 32'(overflow), 32'hf);
        check("t5_req_all", 32'(req_out), 32'hf);
        reset_n = 1'b0;
        tick();
        check("t5_rst_req", 32'(req_out), 32'd0);
        check("t5_rst_pending", 32'(pending_cnt), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ovf", 32'(overflow), 32'd0);
        check("t5_rst_done", 32'(done_pulse), 32'd0);
        tick();
        reset_n = 1'b1;
        rx_en   = '1;
        repeat (3) tick();
        check("t5_post_rst_idle", 32'(busy | req_out), 32'd0);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < NUM_CH; i++) begin
            rx_dly[i]   = $urandom_range(0, 4);
            accepted[i] = 0;
        end
        snap();
        for (int c = 0; c < 800; c++) begin
            m = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 9) == 0 &&
                    (accepted[i] - (done_cnt[i] - base_done[i])) < DEPTH) begin
                    m[i] = 1'b1;
                    accepted[i]++;
                    exp_q.push_back(2'(i));
                end
            end
            pulse_in = m;
            tick();
            if (int'(pend(c % NUM_CH)) > DEPTH)
                check("t6_pend_bound", 32'(pend(c % NUM_CH)), 32'(DEPTH));
        end
        pulse_in = '0;
        wait_quiet("t6", 3000);
        for (int i = 0; i < NUM_CH; i++) exp_done[i] = 0;
        while (exp_q.size() > 0) exp_done[exp_q.pop_front()]++;
        for (int i = 0; i < NUM_CH; i++) begin
            check("t6_done_vs_sb", 32'(done_cnt[i] - base_done[i]), 32'(exp_done[i]));
            check("t6_rises_vs_sb", 32'(rise_cnt[i] - base_rise[i]), 32'(exp_done[i]));
        end
        check("t6_no_ovf", 32'(overflow), 32'd0);
        check("t6_pending_end", 32'(pending_cnt), 32'd0);

`ifdef MULTI_PULSE_HS_TIMEOUT_EN
        // Receiver never answers: watchdog abandons the REQ phase.
        rx_en[0] = 1'b0;
        snap();
        pulse(4'b0001);
        tick();
        check("t7_req_up", 32'(req_out[0]), 32'd1);
        n = 0;
        while (req_out[0] === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t7_req_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
        check("t7_timeout_pulse", 32'(timeout_pulse), 32'b0001);
        check("t7_pending_zero", 32'(pend(0)), 32'd0);
        tick();
        check("t7_timeout_one_cycle", 32'(timeout_pulse), 32'd0);
        check("t7_no_done", 32'(done_cnt[0] - base_done[0]), 32'd0);
        check("t7_idle", 32'(busy[0]), 32'd0);
        rx_en[0] = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_pulse_handshake_tx.md
Name: multi_pulse_handshake_tx

Overview:
- N-channel pulse transmitter: each single-cycle pulse_in becomes one complete 4-phase req/ack handshake toward a receiver in an unrelated clock domain.
- Unlike a single-pulse transfer, pulses arriving while a handshake is in flight are queued per channel, up to DEPTH, instead of being lost.
- Sits on the source side of a clock crossing. ack_in is asynchronous and is synchronised inside the block.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- DEPTH, 7, max pending pulses per channel (1..255); CNT_W = $clog2(DEPTH+1).
- SYNC_STAGES, 2, flops in each ack_in synchroniser (2..4).
- TIMEOUT_CYCLES, 64, watchdog limit per handshake phase (used only with the optional feature).

Ports:
- clock  input  1  single block clock.
- reset_n  input  1  synchronous, active-low reset.
- pulse_in  input  NUM_CH  one-cycle event per channel.
- ack_in  input  NUM_CH  asynchronous acknowledge from receiver.
- req_out  output  NUM_CH  registered request level to receiver.
- pending_cnt  output  NUM_CH*CNT_W  per-channel queued count, channel k at [k*CNT_W +: CNT_W].
- busy  output  NUM_CH  channel state != IDLE or pending_cnt != 0.
- done_pulse  output  NUM_CH  one-cycle pulse when a handshake completes.
- overflow  output  NUM_CH  sticky flag: a pulse was dropped.
- clear_overflow  input  NUM_CH  clears overflow[k] synchronously.

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, counters 0, FSM IDLE. Reset asserted mid-handshake aborts it immediately.
- Channels are fully independent; no arbitration between them.
- ack_s[k] is ack_in[k] after SYNC_STAGES flops.
- Pending counter per channel:
  - +1 when pulse_in is sampled high.
  - -1 on the cycle the FSM moves REQ->WAIT_LOW.
  - Both events in the same cycle: count unchanged.
  - Count == DEPTH with a pulse and no decrement: pulse dropped, count held, overflow set.
  - Count == DEPTH with a pulse and a decrement in the same cycle: pulse accepted, count stays DEPTH, no overflow.
  - Count never wraps.
- Overflow: set has priority over clear_overflow in the same cycle.
- FSM per channel (registered):
  - IDLE: if pending_cnt != 0 -> REQ.
  - REQ: req_out=1; when ack_s=1 -> WAIT_LOW, decrement counter.
  - WAIT_LOW: req_out=0; when ack_s=0 -> IDLE, done_pulse=1 for exactly that cycle.
- Latency:
  - pulse_in high at edge t -> pending_cnt=1 after t -> req_out=1 after t+1.
  - IDLE re-evaluates pending_cnt on the cycle after done_pulse, so back-to-back handshakes have a single IDLE cycle between them.
- ack_s already high while in IDLE (protocol violation): the FSM still enters REQ and passes straight to WAIT_LOW on the next cycle. There is no error flag.
- req_out changes only from FSM state, so it is glitch-free.

Optional Feature:
- Macro: MULTI_PULSE_HS_TIMEOUT_EN.
- Defined:
  - Per-channel watchdog counter, cleared on every state change.
  - If a channel stays TIMEOUT_CYCLES cycles in REQ or WAIT_LOW, the FSM forces IDLE and req_out drops.
  - The pending count is decremented if the timeout occurred in REQ.
  - Extra output timeout_pulse[NUM_CH] fires for one cycle. No done_pulse is issued.
- Undefined: no watchdog logic and no timeout_pulse port; handshakes wait forever.

Decomposition:
- Package multi_pulse_hs_pkg holds:
  - typedef enum logic [1:0] hs_state_t {IDLE, REQ, WAIT_LOW};
  - localparam function cnt_width(depth).
- Sub-module sync_bit (parameter STAGES, ports clock, reset_n, d, q), instantiated NUM_CH times.
- Channel logic lives in a generate loop inside the top module.

Test Plan:
- Single pulse on ch0; ack returns 3 cycles after req rises, drops 3 cycles after req falls -> req_out[0] rises 2 edges after the pulse, exactly one done_pulse[0], pending_cnt ends at 0, other channels stay idle.
- 5 pulses on ch1 every 2 cycles, slow ack (10 cycles per phase) -> pending_cnt peaks at 4 or 5, exactly 5 handshakes and 5 done_pulse, no overflow.
- DEPTH=7: 9 pulses on ch2 with ack held low -> pending_cnt saturates at 7, overflow[2]=1. Assert clear_overflow[2] -> overflow[2]=0 next cycle.
- Pulse on ch3 in the same cycle ack_s rises with count=7 -> count stays 7, no overflow.
- All 4 channels pulsed in the same cycle, ack skewed per channel -> 4 independent handshakes, each done_pulse fires once. Assert reset_n low mid-run -> all outputs 0 on the next edge.
- With MULTI_PULSE_HS_TIMEOUT_EN and TIMEOUT_CYCLES=16: pulse on ch0, ack never returns -> req_out[0] drops after 16 cycles in REQ, timeout_pulse[0]=1 for one cycle, pending_cnt=0, no done_pulse.
